// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI mode-0 master.
package spi_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam logic        MOSI_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

endpackage

// File: rtl/spi_byte_shifter_if.sv
// Host-side byte handshake plus SPI wire signals of the byte shifter.
// The master modport is the shifter's view; slave is the port logic / device side.
interface spi_byte_shifter_if #(
  parameter int unsigned DIV_W = 4
);
  import spi_pkg::*;

  logic [DIV_W-1:0]    iClkDiv;
  logic                iSend;
  logic [SPI_BITS-1:0] iData;
  logic [SPI_BITS-1:0] oData;
  logic                oAvail;
  logic                oTaken;
  logic                oBusy;
  logic                oMosi;
  logic                iMiso;
  logic                oSck;

  modport master (
    input  iClkDiv, iSend, iData, iMiso,
    output oData, oAvail, oTaken, oBusy, oMosi, oSck
  );

  modport slave (
    output iClkDiv, iSend, iData, iMiso,
    input  oData, oAvail, oTaken, oBusy, oMosi, oSck
  );

endinterface

// File: rtl/spi_half_tick.sv
// Loadable down-counter timing one SCK half-period; tick marks the last cycle.
module spi_half_tick #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Count down while enabled; reload on explicit load or on reaching zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period;
    end else if (en) begin
      cnt <= tick ? period : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_shifter.sv
// Byte-wide SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with a one-byte
// holding register for gap-free back-to-back transfers.
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  spi_byte_shifter_if.master bus
);

  localparam int unsigned BIT_W = $clog2(SPI_BITS);

  state_t              state, state_next;
  logic [SPI_BITS-1:0] hold, hold_next;
  logic                hold_vld, hold_vld_next;
  logic [SPI_BITS-1:0] shift, shift_next;
  logic [SPI_BITS-1:0] rx, rx_next;
  logic [BIT_W-1:0]    bitcnt, bitcnt_next;
  logic [DIV_W-1:0]    div, div_next;
  logic                sck, sck_next;
  logic                mosi, mosi_next;
  logic [SPI_BITS-1:0] data, data_next;
  logic                avail, avail_next;
  logic                taken, taken_next;
  logic                busy, busy_next;
  logic                load;
  logic                en;
  logic                tick;
  logic [DIV_W-1:0]    period;

  spi_half_tick #(.W(DIV_W)) u_half_tick (
    .clk    (iClk),
    .rst    (iRst),
    .en     (en),
    .load   (load),
    .period (period),
    .tick   (tick)
  );

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_next    = state;
    hold_next     = hold;
    hold_vld_next = hold_vld;
    shift_next    = shift;
    rx_next       = rx;
    bitcnt_next   = bitcnt;
    div_next      = div;
    sck_next      = sck;
    mosi_next     = mosi;
    data_next     = data;
    avail_next    = 1'b0;
    taken_next    = 1'b0;
    load          = 1'b0;
    en            = 1'b0;

    case (state)
      IDLE: begin
        sck_next  = 1'b0;
        mosi_next = MOSI_IDLE;
        load      = hold_vld;
      end
      LOW: begin
        en = 1'b1;
        if (tick) begin
          sck_next   = 1'b1;
          rx_next    = {rx[SPI_BITS-2:0], bus.iMiso};
          state_next = HIGH;
        end
      end
      HIGH: begin
        en = 1'b1;
        if (tick) begin
          sck_next = 1'b0;
          if (bitcnt != '0) begin
            shift_next  = shift << 1;
            mosi_next   = shift[SPI_BITS-2];
            bitcnt_next = bitcnt - 1'b1;
            state_next  = LOW;
          end else begin
            data_next  = rx;
            avail_next = 1'b1;
            mosi_next  = MOSI_IDLE;
            state_next = IDLE;
            load       = hold_vld;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A load overrides the phase decode above; it also covers the
    // byte-done cycle so the next byte starts without an idle gap.
    if (load) begin
      shift_next    = hold;
      hold_vld_next = 1'b0;
      div_next      = bus.iClkDiv;
      bitcnt_next   = BIT_W'(SPI_BITS - 1);
      mosi_next     = hold[SPI_BITS-1];
      taken_next    = 1'b1;
      state_next    = LOW;
    end

    if (!hold_vld && bus.iSend) begin
      hold_next     = bus.iData;
      hold_vld_next = 1'b1;
    end

    // Current state is included so busy stays up through the byte-done
    // cycle and drops one cycle after the final oAvail.
    busy_next = hold_vld_next || (state != IDLE) || (state_next != IDLE);
  end

  assign period = load ? bus.iClkDiv : div;

  // State and output registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      hold     <= '0;
      hold_vld <= 1'b0;
      shift    <= '0;
      rx       <= '0;
      bitcnt   <= '0;
      div      <= '0;
      sck      <= 1'b0;
      mosi     <= MOSI_IDLE;
      data     <= '0;
      avail    <= 1'b0;
      taken    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      hold     <= hold_next;
      hold_vld <= hold_vld_next;
      shift    <= shift_next;
      rx       <= rx_next;
      bitcnt   <= bitcnt_next;
      div      <= div_next;
      sck      <= sck_next;
      mosi     <= mosi_next;
      data     <= data_next;
      avail    <= avail_next;
      taken    <= taken_next;
      busy     <= busy_next;
    end
  end

  assign bus.oSck   = sck;
  assign bus.oMosi  = mosi;
  assign bus.oData  = data;
  assign bus.oAvail = avail;
  assign bus.oTaken = taken;
  assign bus.oBusy  = busy;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: loopback, slave model, back-to-back,
// overflow, reset abort and divider change. Received bytes go through a queue.
module tb_spi_byte_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_byte_shifter_if #(.DIV_W(4)) bus ();

  spi_byte_shifter #(.DIV_W(4)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  bit         loop = 1'b1;
  logic [7:0] resp = 8'h00;
  logic       slave_miso = 1'b0;
  int         bitidx = 0;
  assign bus.iMiso = loop ? bus.oMosi : slave_miso;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, rises = 0, avail_cnt = 0, taken_cnt = 0, coincide_cnt = 0, mosi_viol = 0;
  int taken_cyc = 0, avail_cyc = 0, busy_fall_cyc = 0, last_edge = 0;
  int min_hi, max_hi, min_lo, max_lo;
  logic sck_prev = 1'b0, mosi_prev = 1'b1, busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    min_hi = 100000; max_hi = 0; min_lo = 100000; max_lo = 0;
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    int len;
    #1;
    cyc++;
    if (bus.oSck && !sck_prev) begin
      rises++;
      len = cyc - last_edge;
      if (len < min_lo) min_lo = len;
      if (len > max_lo) max_lo = len;
      last_edge = cyc;
    end
    if (!bus.oSck && sck_prev) begin
      len = cyc - last_edge;
      if (len < min_hi) min_hi = len;
      if (len > max_hi) max_hi = len;
      last_edge = cyc;
      if (!bus.oTaken && bitidx > 0) begin
        bitidx--;
        slave_miso = resp[bitidx];
      end
    end
    if (bus.oTaken) begin
      taken_cnt++;
      taken_cyc = cyc;
      last_edge = cyc;
      bitidx = 7;
      slave_miso = resp[7];
    end
    if (bus.oAvail) begin
      avail_cnt++;
      avail_cyc = cyc;
      if (bus.oTaken) coincide_cnt++;
      chk("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rx_data", 32'(bus.oData), 32'(exp_q.pop_front()));
    end
    if (!bus.oBusy && busy_prev) busy_fall_cyc = cyc;
    if (bus.oMosi !== mosi_prev && !(sck_prev && !bus.oSck) && !bus.oTaken && !rst) mosi_viol++;
    sck_prev  = bus.oSck;
    mosi_prev = bus.oMosi;
    busy_prev = bus.oBusy;
  end

  task automatic send(input logic [7:0] b);
    bus.iData = b;
    bus.iSend = 1'b1;
    @(negedge clk);
    bus.iSend = 1'b0;
  endtask

  task automatic wait_avail(input int target, input int lim, input string tag);
    int i = 0;
    while (avail_cnt < target && i < lim) begin @(negedge clk); i++; end
    chk(tag, 32'(avail_cnt >= target), 1);
  endtask

  task automatic wait_taken(input int target, input int lim, input string tag);
    int i = 0;
    while (taken_cnt < target && i < lim) begin @(negedge clk); i++; end
    chk(tag, 32'(taken_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int i = 0;
    while (bus.oBusy !== 1'b0 && i < lim) begin @(negedge clk); i++; end
    chk(tag, 32'(bus.oBusy === 1'b0), 1);
  endtask

  initial begin
    int n0, r0, a0, t0, a1;
    bus.iSend = 1'b0;
    bus.iData = 8'h00;
    bus.iClkDiv = 4'd0;
    reset_stats();
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_sck",   32'(bus.oSck), 0);
    chk("rst_mosi",  32'(bus.oMosi), 1);
    chk("rst_data",  32'(bus.oData), 0);
    chk("rst_avail", 32'(bus.oAvail), 0);
    chk("rst_taken", 32'(bus.oTaken), 0);
    chk("rst_busy",  32'(bus.oBusy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback, D=0
    loop = 1'b1;
    bus.iClkDiv = 4'd0;
    n0 = cyc; r0 = rises; a0 = avail_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5);
    chk("lb_busy_n1", 32'(bus.oBusy), 1);
    wait_avail(a0 + 1, 100, "lb_avail_seen");
    chk("lb_taken_cyc", 32'(taken_cyc), 32'(n0 + 2));
    chk("lb_avail_cyc", 32'(avail_cyc), 32'(n0 + 18));
    chk("lb_rises", 32'(rises - r0), 8);
    chk("lb_data", 32'(bus.oData), 32'h A5);
    wait_idle(20, "lb_idle");

    // Slave model, D=15, sends 0xFF and receives 0x3C
    loop = 1'b0;
    resp = 8'h3C;
    bus.iClkDiv = 4'd15;
    reset_stats();
    a0 = avail_cnt;
    exp_q.push_back(8'h3C);
    send(8'hFF);
    wait_avail(a0 + 1, 400, "sl_avail_seen");
    chk("sl_duration", 32'(avail_cyc - taken_cyc), 256);
    chk("sl_min_hi", 32'(min_hi), 16);
    chk("sl_max_hi", 32'(max_hi), 16);
    chk("sl_min_lo", 32'(min_lo), 16);
    chk("sl_max_lo", 32'(max_lo), 16);
    wait_idle(20, "sl_idle");
    repeat (2) @(negedge clk);
    chk("sl_mosi_idle", 32'(bus.oMosi), 1);

    // Back-to-back, D=1
    loop = 1'b1;
    bus.iClkDiv = 4'd1;
    reset_stats();
    a0 = avail_cnt; t0 = taken_cnt; n0 = coincide_cnt;
    exp_q.push_back(8'h01);
    send(8'h01);
    wait_taken(t0 + 1, 20, "b2b_first_taken");
    exp_q.push_back(8'h02);
    send(8'h02);
    wait_avail(a0 + 2, 200, "b2b_two_avail");
    chk("b2b_coincide", 32'(coincide_cnt - n0), 1);
    chk("b2b_max_lo", 32'(max_lo), 2);
    chk("b2b_max_hi", 32'(max_hi), 2);
    a1 = avail_cyc;
    wait_idle(20, "b2b_idle");
    chk("b2b_busy_fall", 32'(busy_fall_cyc), 32'(a1 + 1));

    // Overflow: three consecutive strobes while a byte is shifting
    bus.iClkDiv = 4'd0;
    a0 = avail_cnt; t0 = taken_cnt;
    exp_q.push_back(8'h5A);
    send(8'h5A);
    wait_taken(t0 + 1, 20, "ovf_first_taken");
    exp_q.push_back(8'h11);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_idle(200, "ovf_idle");
    repeat (40) @(negedge clk);
    chk("ovf_avail_cnt", 32'(avail_cnt - a0), 2);
    chk("ovf_sb_empty", 32'(exp_q.size()), 0);

    // Reset mid-transfer, with a byte queued in the holding register
    bus.iClkDiv = 4'd3;
    r0 = rises; t0 = taken_cnt;
    send(8'hC3);
    wait_taken(t0 + 1, 20, "rst_taken_seen");
    send(8'h77);
    begin
      int i = 0;
      while (rises - r0 < 3 && i < 200) begin @(negedge clk); i++; end
    end
    chk("rst_three_rises", 32'(rises - r0), 3);
    rst = 1'b1;
    a0 = avail_cnt;
    @(negedge clk);
    chk("mid_sck",  32'(bus.oSck), 0);
    chk("mid_mosi", 32'(bus.oMosi), 1);
    chk("mid_busy", 32'(bus.oBusy), 0);
    chk("mid_data", 32'(bus.oData), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_no_avail", 32'(avail_cnt - a0), 0);
    chk("mid_hold_dropped", 32'(bus.oBusy), 0);

    // Divider change mid-byte: 3 -> 1
    bus.iClkDiv = 4'd3;
    reset_stats();
    a0 = avail_cnt; t0 = taken_cnt; r0 = rises;
    exp_q.push_back(8'h96);
    send(8'h96);
    wait_taken(t0 + 1, 20, "div_first_taken");
    exp_q.push_back(8'h69);
    send(8'h69);
    begin
      int i = 0;
      while (rises - r0 < 2 && i < 100) begin @(negedge clk); i++; end
    end
    bus.iClkDiv = 4'd1;
    wait_avail(a0 + 1, 200, "div_first_avail");
    a1 = avail_cyc;
    chk("div_b1_min_hi", 32'(min_hi), 4);
    chk("div_b1_max_hi", 32'(max_hi), 4);
    chk("div_b1_min_lo", 32'(min_lo), 4);
    chk("div_b1_max_lo", 32'(max_lo), 4);
    reset_stats();
    wait_avail(a0 + 2, 200, "div_second_avail");
    chk("div_b2_min_hi", 32'(min_hi), 2);
    chk("div_b2_max_hi", 32'(max_hi), 2);
    chk("div_b2_max_lo", 32'(max_lo), 2);
    chk("div_b2_duration", 32'(avail_cyc - a1), 32);
    wait_idle(20, "div_idle");

    chk("mosi_changes_legal", 32'(mosi_viol), 0);
    chk("sb_final_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
